step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/tr_pkg.sv | 20 ++
 rtl/step_sequencer_if.sv | 31 +++
 rtl/step_ramp.sv | 33 +++
 rtl/step_sequencer.sv | 160 ++++++++++++++++
 tb/tb_step_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tr_pkg.sv
// Shared definitions for the step sequencer and the tracking controller:
// sequencer state encoding and default timing parameters in clk cycles.
package tr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIR_SETUP = 2'd1,
    ST_STEP_HIGH = 2'd2,
    ST_STEP_LOW  = 2'd3
  } state_t;

  localparam int DEF_WIDTH_WORK   = 16;
  localparam int DEF_WIDTH_POS    = 32;
  localparam int DEF_PULSE_W      = 100;
  localparam int DEF_DIR_SETUP    = 250;
  localparam int DEF_PERIOD_START = 5000;
  localparam int DEF_PERIOD_MIN   = 400;
  localparam int DEF_RAMP_STEP    = 20;

endpackage

// File: rtl/step_sequencer_if.sv
// Command and status bundle between the tracking controller (master) and the
// step sequencer (slave).
interface step_sequencer_if #(
  parameter int WIDTH_WORK = tr_pkg::DEF_WIDTH_WORK,
  parameter int WIDTH_POS  = tr_pkg::DEF_WIDTH_POS
);

  // No handshake: enable/dir_req/period are level commands that the sequencer
  // samples only in IDLE or at the end of a step; changes at other times wait.
  logic                         enable;
  logic                         dir_req;
  logic [WIDTH_WORK-1:0]        period;

  logic                         drv_step;
  logic                         drv_dir;
  logic                         busy;
  logic signed [WIDTH_POS-1:0]  position;
  logic [WIDTH_WORK-1:0]        cur_period;
  tr_pkg::state_t               state;

  modport master (
    output enable, dir_req, period,
    input  drv_step, drv_dir, busy, position, cur_period, state
  );

  modport slave (
    input  enable, dir_req, period,
    output drv_step, drv_dir, busy, position, cur_period, state
  );

endinterface

// File: rtl/step_ramp.sv
// Combinational ramp: moves the current step period toward the target by at
// most ramp_step, never overshooting the target.
module step_ramp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] ramp_step,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] tgt_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] next_x;

  assign cur_x  = {1'b0, cur};
  assign tgt_x  = {1'b0, target};
  assign step_x = {1'b0, ramp_step};

  always_comb begin
    next_x = tgt_x;
    if (cur_x > tgt_x) begin
      if ((cur_x - tgt_x) > step_x) next_x = cur_x - step_x;
    end else if (cur_x < tgt_x) begin
      if ((tgt_x - cur_x) > step_x) next_x = cur_x + step_x;
    end
  end

  // An out-of-range intermediate can only come from a bad target; fall back to it.
  assign next = next_x[WIDTH] ? target : next_x[WIDTH-1:0];

endmodule

// File: rtl/step_sequencer.sv
// Step/direction pulse generator with trapezoidal period ramping, direction
// setup time and a signed position counter.
module step_sequencer
  import tr_pkg::*;
#(
  parameter int WIDTH_WORK   = DEF_WIDTH_WORK,
  parameter int WIDTH_POS    = DEF_WIDTH_POS,
  parameter int PULSE_W      = DEF_PULSE_W,
  parameter int DIR_SETUP    = DEF_DIR_SETUP,
  parameter int PERIOD_START = DEF_PERIOD_START,
  parameter int PERIOD_MIN   = DEF_PERIOD_MIN,
  parameter int RAMP_STEP    = DEF_RAMP_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  step_sequencer_if.slave   bus
);

  localparam logic [WIDTH_WORK-1:0] P_START      = WIDTH_WORK'(PERIOD_START);
  localparam logic [WIDTH_WORK-1:0] P_MIN        = WIDTH_WORK'(PERIOD_MIN);
  localparam logic [WIDTH_WORK-1:0] P_RAMP       = WIDTH_WORK'(RAMP_STEP);
  localparam logic [WIDTH_WORK-1:0] P_PULSE_LAST = WIDTH_WORK'(PULSE_W - 1);
  localparam logic [WIDTH_WORK-1:0] P_SETUP_LAST = WIDTH_WORK'(DIR_SETUP - 1);
  localparam logic [WIDTH_WORK-1:0] P_LOW_TRIM   = WIDTH_WORK'(PULSE_W + 1);
  localparam logic signed [WIDTH_POS-1:0] POS_ONE = WIDTH_POS'(1);

  state_t                       state, state_n;
  logic [WIDTH_WORK-1:0]        timer, timer_n;
  logic [WIDTH_WORK-1:0]        cur_period, cur_period_n;
  logic                         drv_step, drv_step_n;
  logic                         drv_dir, drv_dir_n;
  logic signed [WIDTH_POS-1:0]  position, position_n;
  logic signed [WIDTH_POS-1:0]  position_stepped;

  logic [WIDTH_WORK-1:0]        ramp_target;
  logic [WIDTH_WORK-1:0]        ramp_next;
  logic                         go;
  logic                         dir_change;
  logic                         timer_done;

  assign go               = bus.enable && (bus.period != '0);
  assign dir_change       = (bus.dir_req != drv_dir);
  assign timer_done       = (timer == '0);
  assign position_stepped = drv_dir ? position + POS_ONE : position - POS_ONE;

  // A pending reversal decelerates toward the start period before flipping.
  always_comb begin
    if (dir_change)               ramp_target = P_START;
    else if (bus.period < P_MIN)  ramp_target = P_MIN;
    else if (bus.period > P_START) ramp_target = P_START;
    else                          ramp_target = bus.period;
  end

  step_ramp #(.WIDTH(WIDTH_WORK)) u_ramp (
    .cur       (cur_period),
    .target    (ramp_target),
    .ramp_step (P_RAMP),
    .next      (ramp_next)
  );

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    cur_period_n = cur_period;
    drv_step_n   = drv_step;
    drv_dir_n    = drv_dir;
    position_n   = position;

    case (state)
      ST_IDLE: begin
        if (go) begin
          cur_period_n = P_START;
          if (dir_change) begin
            state_n   = ST_DIR_SETUP;
            drv_dir_n = bus.dir_req;
            timer_n   = P_SETUP_LAST;
          end else begin
            state_n    = ST_STEP_HIGH;
            drv_step_n = 1'b1;
            timer_n    = P_PULSE_LAST;
            position_n = position_stepped;
          end
        end
      end

      ST_DIR_SETUP: begin
        if (timer_done) begin
          state_n    = ST_STEP_HIGH;
          drv_step_n = 1'b1;
          timer_n    = P_PULSE_LAST;
          position_n = position_stepped;
        end else begin
          timer_n = timer - 1'b1;
        end
      end

      ST_STEP_HIGH: begin
        if (timer_done) begin
          state_n    = ST_STEP_LOW;
          drv_step_n = 1'b0;
          // Low phase fills the rest of the step so rise-to-rise equals cur_period.
          timer_n    = cur_period - P_LOW_TRIM;
        end else begin
          timer_n = timer - 1'b1;
        end
      end

      ST_STEP_LOW: begin
        if (timer_done) begin
          if (!go) begin
            state_n = ST_IDLE;
          end else if (dir_change && (cur_period >= P_START)) begin
            state_n   = ST_DIR_SETUP;
            drv_dir_n = bus.dir_req;
            timer_n   = P_SETUP_LAST;
          end else begin
            state_n      = ST_STEP_HIGH;
            cur_period_n = ramp_next;
            drv_step_n   = 1'b1;
            timer_n      = P_PULSE_LAST;
            position_n   = position_stepped;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end

      default: begin
        state_n    = ST_IDLE;
        drv_step_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      timer      <= '0;
      cur_period <= '0;
      drv_step   <= 1'b0;
      drv_dir    <= 1'b0;
      position   <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      cur_period <= cur_period_n;
      drv_step   <= drv_step_n;
      drv_dir    <= drv_dir_n;
      position   <= position_n;
    end
  end

  assign bus.drv_step   = drv_step;
  assign bus.drv_dir    = drv_dir;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.position   = position;
  assign bus.cur_period = cur_period;
  assign bus.state      = state;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed motion profiles plus random commands,
// checked cycle by cycle against a step-schedule reference model.
module tb_step_sequencer;
  import tr_pkg::*;

  localparam int WW = 16;
  localparam int WP = 32;
  localparam int PW = 4;
  localparam int DS = 10;
  localparam int PS = 40;
  localparam int PM = 10;
  localparam int RS = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  step_sequencer_if #(.WIDTH_WORK(WW), .WIDTH_POS(WP)) bus ();

  step_sequencer #(
    .WIDTH_WORK(WW), .WIDTH_POS(WP), .PULSE_W(PW), .DIR_SETUP(DS),
    .PERIOD_START(PS), .PERIOD_MIN(PM), .RAMP_STEP(RS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the step schedule: when the next step rises and when the next
  // end-of-step decision is due, derived from the period and setup rules.
  int          cyc      = 0;
  bit          m_active = 1'b0;
  bit          m_dir    = 1'b0;
  logic [31:0] m_pos    = '0;
  int          m_per    = 0;
  int          m_rise   = -1000;
  int          m_next   = -1;

  function automatic int clamp_period(int p);
    if (p < PM) return PM;
    if (p > PS) return PS;
    return p;
  endfunction

  function automatic int toward(int cur, int tgt);
    int d;
    d = tgt - cur;
    if (d > RS) d = RS;
    else if (d < -RS) d = -RS;
    return cur + d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_dir = 1'b0; m_pos = '0; m_per = 0;
      m_rise = -1000; m_next = -1;
    end else begin
      cyc = cyc + 1;
      if (m_active && cyc == m_next) begin
        if (!bus.enable || bus.period == 0) begin
          m_active = 1'b0;
        end else if (bus.dir_req != m_dir) begin
          if (m_per >= PS) begin
            m_dir  = bus.dir_req;
            m_rise = cyc + DS;
          end else begin
            m_per  = toward(m_per, PS);
            m_rise = cyc;
          end
        end else begin
          m_per  = toward(m_per, clamp_period(int'(bus.period)));
          m_rise = cyc;
        end
      end else if (!m_active && bus.enable && bus.period != 0) begin
        m_active = 1'b1;
        m_per    = PS;
        if (bus.dir_req != m_dir) begin
          m_dir  = bus.dir_req;
          m_rise = cyc + DS;
        end else begin
          m_rise = cyc;
        end
      end
      if (m_active && cyc == m_rise) begin
        m_pos  = m_dir ? m_pos + 1 : m_pos - 1;
        m_next = cyc + m_per;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_q[$];
  int          rise_q[$];
  int          dir_chg_cyc   = 0;
  int          fall_cyc      = 0;
  int          busy_fall_cyc = 0;
  logic        prev_step = 1'b0, prev_dir = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("busy",       32'(bus.busy),       32'(m_active));
      check_eq("drv_dir",    32'(bus.drv_dir),    32'(m_dir));
      check_eq("position",   bus.position,        m_pos);
      check_eq("cur_period", 32'(bus.cur_period), 32'(m_per));
      check_eq("drv_step",   32'(bus.drv_step),
               32'(m_active && cyc >= m_rise && cyc < m_rise + PW));
      if (bus.drv_step && !prev_step) rise_q.push_back(cyc);
      if (!bus.drv_step && prev_step) fall_cyc = cyc;
      if (!bus.busy && prev_busy)     busy_fall_cyc = cyc;
      if (bus.drv_dir != prev_dir) begin
        dir_chg_cyc = cyc;
        check_eq("dir_flip_step_low", 32'(bus.drv_step), 32'd0);
      end
    end
    prev_step = bus.drv_step;
    prev_dir  = bus.drv_dir;
    prev_busy = bus.busy;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit en, input bit dir, input int per);
    bus.enable  = en;
    bus.dir_req = dir;
    bus.period  = WW'(per);
  endtask

  task automatic wait_rises(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rise_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 32'(rise_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (bus.busy && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_periods(input string tag);
    for (int i = 1; i < rise_q.size(); i++) begin
      if (exp_q.size() > 0) check_eq(tag, 32'(rise_q[i] - rise_q[i-1]), exp_q.pop_front());
    end
    check_eq({tag, "_all_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b1, 1'b1, 20);
    #12;
    check_eq("rst_drv_step",   32'(bus.drv_step),   32'd0);
    check_eq("rst_drv_dir",    32'(bus.drv_dir),    32'd0);
    check_eq("rst_busy",       32'(bus.busy),       32'd0);
    check_eq("rst_position",   bus.position,        32'd0);
    check_eq("rst_cur_period", 32'(bus.cur_period), 32'd0);
    check_eq("rst_state",      32'(bus.state),      32'(ST_IDLE));

    // Forced reversal from reset, ramp to 20, reverse, then clamp at minimum.
    @(negedge clk); #1;
    rst_n = 1'b1;
    wait_rises(1, 40, "first_rise_timeout");
    check_eq("setup_gap", 32'(rise_q[0] - dir_chg_cyc), 32'(DS));
    wait_rises(7, 400, "ramp_up_timeout");
    drive(1'b1, 1'b0, 20);
    wait_rises(17, 800, "reverse_timeout");
    drive(1'b1, 1'b0, 3);
    wait_rises(21, 400, "clamp_timeout");
    check_eq("pos_after_reverse", bus.position, 32'd1);
    begin
      logic [31:0] prof[20];
      prof = '{40, 35, 30, 25, 20, 20, 20, 25, 30, 35, 50, 40, 35, 30, 25, 20, 20, 15, 10, 10};
      foreach (prof[i]) exp_q.push_back(prof[i]);
    end
    check_periods("step_period");

    // period=0 stops after the current step.
    drive(1'b1, 1'b0, 0);
    wait_idle(60, "stop_timeout");
    check_eq("stop_latency", 32'(busy_fall_cyc - rise_q[20]), 32'd10);
    check_eq("no_extra_rise", 32'(rise_q.size()), 32'd21);

    // enable dropped one cycle into the pulse: full pulse, stop at step end.
    drive(1'b1, 1'b0, 20);
    wait_rises(22, 20, "restart_timeout");
    tick(1);
    drive(1'b0, 1'b0, 20);
    wait_idle(80, "disable_timeout");
    check_eq("pulse_width", 32'(fall_cyc - rise_q[21]), 32'(PW));
    check_eq("disable_latency", 32'(busy_fall_cyc - rise_q[21]), 32'(PS));

    // Asynchronous reset in the middle of a pulse, then a fresh ramp.
    drive(1'b1, 1'b1, 20);
    wait_rises(23, 40, "pre_reset_timeout");
    rst_n = 1'b0;
    #1;
    check_eq("arst_drv_step", 32'(bus.drv_step), 32'd0);
    check_eq("arst_position", bus.position,      32'd0);
    check_eq("arst_busy",     32'(bus.busy),     32'd0);
    check_eq("arst_drv_dir",  32'(bus.drv_dir),  32'd0);
    rise_q.delete();
    tick(2);
    rst_n = 1'b1;
    wait_rises(3, 200, "post_reset_timeout");
    check_eq("post_reset_setup_gap", 32'(rise_q[0] - dir_chg_cyc), 32'(DS));
    exp_q.push_back(32'd40);
    exp_q.push_back(32'd35);
    check_periods("post_reset_period");

    // Random commands; the per-cycle model comparison does the checking.
    for (int seg = 0; seg < 40; seg++) begin
      int per;
      per = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 60));
      drive(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), per);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      tick($urandom_range(1, 150));
    end
    drive(1'b0, 1'b0, 0);
    wait_idle(200, "final_idle_timeout");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    check_eq("watchdog", 32'd0, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
